parse_lattice_rowslice: RTL and testbench



---
 rtl/parse_lattice_rowslice_pkg.sv | 43 ++++
 rtl/parse_lattice_rowslice_uev_cell.sv | 34 +++
 rtl/parse_lattice_rowslice.sv | 211 +++++++++++++++++++++
 tb/tb_parse_lattice_rowslice.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/parse_lattice_rowslice_pkg.sv
// Shared types and constants for the row-slice CAVLC slice-layer parser.
// Field order, stream constants and the exp-Golomb length helper.
package parse_lattice_rowslice_pkg;

    localparam int MB_WIDTH_DEF = 11;

    localparam logic [4:0] ST_P  = 5'd0;
    localparam logic [4:0] ST_P2 = 5'd5;
    localparam logic [4:0] ST_I  = 5'd2;
    localparam logic [4:0] ST_I2 = 5'd7;

    localparam logic [4:0] NAL_SLICE = 5'd1;
    localparam logic [4:0] NAL_IDR   = 5'd5;

    typedef enum logic [3:0] {
        F_FIRST,
        F_TYPE,
        F_PPS,
        F_FRAME,
        F_IDR,
        F_OVR,
        F_MOD,
        F_DRPM,
        F_QP,
        F_IDC,
        F_ALPHA,
        F_BETA,
        F_DONE
    } fld_e;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_HDR,
        PH_SLOT,
        PH_MB,
        PH_WAIT
    } ph_e;

    function automatic logic [5:0] eg_len(input logic [4:0] lz);
        return {lz, 1'b1};
    endfunction

endpackage

// File: rtl/parse_lattice_rowslice_uev_cell.sv
// One lattice cell: exp-Golomb decode of the code starting at this bit.
// The window is 31 bits, MSB earliest; longer codes report len 31.
module parse_lattice_rowslice_uev_cell
    import parse_lattice_rowslice_pkg::*;
(
    input  logic [30:0] win_i,
    output logic [5:0]  len_o,
    output logic [15:0] val_o
);

    logic [4:0]  lz;
    logic [15:0] sfx;

    always_comb begin
        lz = 5'd16;
        for (int k = 15; k >= 0; k--) begin
            if (win_i[30-k]) lz = 5'(k);
        end
        sfx = '0;
        if (lz < 5'd16) begin
            for (int j = 0; j < 15; j++) begin
                if (j < int'(lz)) sfx = {sfx[14:0], win_i[29-int'(lz)-j]};
            end
        end
        if (lz == 5'd16) begin
            len_o = 6'd31;
            val_o = '0;
        end else begin
            len_o = eg_len(lz);
            val_o = 16'((17'd1 << lz) - 17'd1) + sfx;
        end
    end

endmodule

// File: rtl/parse_lattice_rowslice.sv
// Slice-layer parser: walks header fields and mb_skip_run codes across
// a WID-bit word, emitting one-hot macroblock starts in the same cycle.
module parse_lattice_rowslice
    import parse_lattice_rowslice_pkg::*;
#(
    parameter int WID            = 128,
    parameter int MB_WIDTH       = MB_WIDTH_DEF,
    parameter int FRAME_NUM_BITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WID-1:0]   in_bits,
    input  logic [31:0]      in_pad,
    input  logic [WID/8-1:0] slice_start,
    input  logic [WID/8-1:0] slice_end,
    input  logic [WID-1:0]   mb_end,
    output logic [WID-1:0]   mb_start,
    output logic [WID-1:0]   mb_left_oop,
    output logic [WID-1:0]   mb_above_oop
);

    localparam int NB  = WID / 8;
    localparam int MBW = $clog2(MB_WIDTH + 1);

    logic [WID+31:0] win;
    logic [WID+4:0]  nal_src;
    logic [5:0]      ul [WID];
    logic [15:0]     uv [WID];

    logic [31:0]    hdr_off_q, hdr_off_d;
    logic [31:0]    skip_off_q, skip_off_d;
    logic [31:0]    mbs_off_q, mbs_off_d;
    logic           wait_q, wait_d;
    fld_e           fld_q, fld_d;
    logic [MBW-1:0] mb_x_q, mb_x_d;
    logic           is_p_q, is_p_d;
    logic           is_idr_q, is_idr_d;
    logic           idc1_q, idc1_d;
    logic [4:0]     last_nal_q;

    ph_e        ph;
    fld_e       fld;
    fld_e       nf;
    int         pos;
    int         mbx;
    int         len;
    int         b;
    logic       isp;
    logic       idr;
    logic       idc1;

    assign win     = {in_bits, in_pad};
    assign nal_src = {last_nal_q, in_bits};

    for (genvar g = 0; g < WID; g++) begin : g_cell
        parse_lattice_rowslice_uev_cell u_cell (
            .win_i (win[WID+31-g -: 31]),
            .len_o (ul[g]),
            .val_o (uv[g])
        );
    end

    function automatic int oh_pos(input logic [31:0] v);
        oh_pos = 0;
        for (int k = 0; k < 32; k++) begin
            if (v[k]) oh_pos = k;
        end
    endfunction

    function automatic logic [31:0] to_oh(input int p);
        for (int k = 0; k < 32; k++) to_oh[k] = (p == WID + k);
    endfunction

    function automatic fld_e next_fld(input fld_e f, input logic p,
                                      input logic i5, input logic d1);
        unique case (f)
            F_FIRST: next_fld = F_TYPE;
            F_TYPE:  next_fld = F_PPS;
            F_PPS:   next_fld = F_FRAME;
            F_FRAME: next_fld = i5 ? F_IDR : (p ? F_OVR : F_DRPM);
            F_IDR:   next_fld = p ? F_OVR : F_DRPM;
            F_OVR:   next_fld = F_MOD;
            F_MOD:   next_fld = F_DRPM;
            F_DRPM:  next_fld = F_QP;
            F_QP:    next_fld = F_IDC;
            F_IDC:   next_fld = d1 ? F_DONE : F_ALPHA;
            F_ALPHA: next_fld = F_BETA;
            default: next_fld = F_DONE;
        endcase
    endfunction

    always_comb begin
        mb_start    = '0;
        mb_left_oop = '0;
        ph   = PH_IDLE;
        fld  = fld_q;
        nf   = F_DONE;
        pos  = 0;
        len  = 1;
        b    = 0;
        mbx  = int'(mb_x_q);
        isp  = is_p_q;
        idr  = is_idr_q;
        idc1 = idc1_q;
        if (hdr_off_q != '0) begin
            ph  = PH_HDR;
            pos = oh_pos(hdr_off_q);
        end else if (skip_off_q != '0) begin
            ph  = PH_SLOT;
            pos = oh_pos(skip_off_q);
        end else if (mbs_off_q != '0) begin
            ph  = PH_MB;
            pos = oh_pos(mbs_off_q);
        end else if (wait_q) begin
            ph = PH_WAIT;
        end

        for (int i = 0; i < WID; i++) begin
            if (i % 8 == 0) begin
                b = NB - 1 - i / 8;
                if (slice_end[b]) ph = PH_IDLE;
                if (slice_start[b]) begin
                    ph  = PH_HDR;
                    fld = F_FIRST;
                    pos = i;
                    mbx = 0;
                    idr = (nal_src[8*(b+1) +: 5] == NAL_IDR);
                end
            end
            if (ph == PH_WAIT && mb_end[WID-1-i]) begin
                mbx = mbx + 1;
                pos = i;
                ph  = (mbx < MB_WIDTH) ? PH_SLOT : PH_IDLE;
            end
            if (ph == PH_SLOT && pos == i) begin
                if (isp) begin
                    mbx = mbx + int'(uv[i]);
                    pos = i + int'(ul[i]);
                    ph  = (mbx < MB_WIDTH) ? PH_MB : PH_IDLE;
                end else begin
                    ph = PH_MB;
                end
            end
            if (ph == PH_MB && pos == i) begin
                mb_start[WID-1-i]    = 1'b1;
                mb_left_oop[WID-1-i] = (mbx == 0);
                ph = PH_WAIT;
            end
            if (ph == PH_HDR && pos == i) begin
                unique case (fld)
                    F_TYPE: begin
                        len = int'(ul[i]);
                        isp = (uv[i] == 16'(ST_P)) || (uv[i] == 16'(ST_P2));
                    end
                    F_IDC: begin
                        len  = int'(ul[i]);
                        idc1 = (uv[i] == 16'd1);
                    end
                    F_FRAME:      len = FRAME_NUM_BITS;
                    F_OVR, F_MOD: len = 1;
                    F_DRPM:       len = idr ? 2 : 1;
                    default:      len = int'(ul[i]);
                endcase
                nf  = next_fld(fld, isp, idr, idc1);
                pos = i + len;
                if (nf == F_DONE) ph = PH_SLOT;
                else fld = nf;
            end
        end

        hdr_off_d  = (ph == PH_HDR)  ? to_oh(pos) : '0;
        skip_off_d = (ph == PH_SLOT) ? to_oh(pos) : '0;
        mbs_off_d  = (ph == PH_MB)   ? to_oh(pos) : '0;
        wait_d     = (ph == PH_WAIT);
        fld_d      = fld;
        mb_x_d     = MBW'((mbx > MB_WIDTH) ? MB_WIDTH : mbx);
        is_p_d     = isp;
        is_idr_d   = idr;
        idc1_d     = idc1;
    end

    // The row above always belongs to another slice.
    assign mb_above_oop = mb_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_off_q  <= '0;
            skip_off_q <= '0;
            mbs_off_q  <= '0;
            wait_q     <= 1'b0;
            fld_q      <= F_FIRST;
            mb_x_q     <= '0;
            is_p_q     <= 1'b0;
            is_idr_q   <= 1'b0;
            idc1_q     <= 1'b0;
            last_nal_q <= '0;
        end else begin
            hdr_off_q  <= hdr_off_d;
            skip_off_q <= skip_off_d;
            mbs_off_q  <= mbs_off_d;
            wait_q     <= wait_d;
            fld_q      <= fld_d;
            mb_x_q     <= mb_x_d;
            is_p_q     <= is_p_d;
            is_idr_q   <= is_idr_d;
            idc1_q     <= idc1_d;
            last_nal_q <= in_bits[4:0];
        end
    end

endmodule

// File: tb/tb_parse_lattice_rowslice.sv
// Directed bench: hand-built slice words, expected start bits per cycle.
// Each cycle checks mb_start, mb_left_oop and mb_above_oop.
module tb_parse_lattice_rowslice;

    localparam int WID = 128;
    localparam int NB  = WID / 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [WID-1:0] in_bits;
    logic [31:0]    in_pad;
    logic [NB-1:0]  slice_start;
    logic [NB-1:0]  slice_end;
    logic [WID-1:0] mb_end;
    logic [WID-1:0] mb_start;
    logic [WID-1:0] mb_left_oop;
    logic [WID-1:0] mb_above_oop;

    int n_cmp = 0;
    int n_bad = 0;
    int n_starts = 0;

    always #5 clk = ~clk;

    parse_lattice_rowslice #(
        .WID            (WID),
        .MB_WIDTH       (11),
        .FRAME_NUM_BITS (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_bits      (in_bits),
        .in_pad       (in_pad),
        .slice_start  (slice_start),
        .slice_end    (slice_end),
        .mb_end       (mb_end),
        .mb_start     (mb_start),
        .mb_left_oop  (mb_left_oop),
        .mb_above_oop (mb_above_oop)
    );

    task automatic check(input string tag, input logic [WID-1:0] got,
                         input logic [WID-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [WID-1:0] pb(input int p);
        pb = '0;
        pb[WID-1-p] = 1'b1;
    endfunction

    task automatic put(input int p, input int n, input logic [31:0] v);
        for (int j = 0; j < n; j++) begin
            if (p + j < WID) in_bits[WID-1-(p+j)] = v[n-1-j];
            else in_pad[31-(p+j-WID)] = v[n-1-j];
        end
    endtask

    task automatic clr();
        in_bits     = '0;
        in_pad      = '0;
        slice_start = '0;
        slice_end   = '0;
        mb_end      = '0;
    endtask

    task automatic step(input string tag, input logic [WID-1:0] es,
                        input logic [WID-1:0] el);
        @(negedge clk);
        check({tag, ".start"}, mb_start, es);
        check({tag, ".left"}, mb_left_oop, el);
        check({tag, ".above"}, mb_above_oop, es);
        n_starts += $countones(mb_start);
        @(posedge clk);
        #1;
    endtask

    // IDR I slice: nal 0x65, then 0x88 0x84 0xA0; first MB at p+20.
    task automatic i_hdr(input int p);
        put(p - 8, 8, 32'h65);
        put(p, 8, 32'h88);
        put(p + 8, 8, 32'h84);
        put(p + 16, 8, 32'hA0);
    endtask

    // Non-IDR P slice header at pos 8 ending at 26.
    task automatic p_hdr();
        put(0, 8, 32'h41);
        put(8, 1, 32'h1);
        put(9, 5, 32'b00110);
        put(14, 1, 32'h1);
        put(15, 4, 32'h0);
        put(19, 3, 32'h0);
        put(22, 1, 32'h1);
        put(23, 3, 32'b010);
    endtask

    initial begin
        reset = 1'b1;
        clr();
        @(posedge clk);
        #1;
        step("rst", '0, '0);

        clr();
        i_hdr(8);
        slice_start[14] = 1'b1;
        step("rstcomb", pb(28), pb(28));
        clr();
        step("rsthold", '0, '0);
        reset = 1'b0;

        clr();
        i_hdr(8);
        slice_start[14] = 1'b1;
        n_starts = 0;
        step("t1.0", pb(28), pb(28));
        for (int k = 1; k <= 10; k++) begin
            clr();
            mb_end = pb(40);
            step($sformatf("t1.%0d", k), pb(40), '0);
        end
        clr();
        mb_end = pb(40);
        step("t1.end", '0, '0);
        clr();
        mb_end = pb(40);
        step("t1.idle", '0, '0);
        check("t1.count", WID'(n_starts), WID'(11));

        clr();
        p_hdr();
        put(26, 5, 32'b00100);
        slice_start[14] = 1'b1;
        n_starts = 0;
        step("t2.0", pb(31), '0);
        for (int k = 1; k <= 7; k++) begin
            clr();
            mb_end = pb(64);
            put(64, 1, 32'h1);
            step($sformatf("t2.%0d", k), pb(65), '0);
        end
        clr();
        mb_end = pb(64);
        put(64, 1, 32'h1);
        step("t2.end", '0, '0);
        check("t2.count", WID'(n_starts), WID'(8));

        clr();
        p_hdr();
        put(26, 7, 32'b0001100);
        put(120, 8, 32'h65);
        slice_start[14] = 1'b1;
        step("t3.0", '0, '0);
        clr();
        put(0, 8, 32'h88);
        put(8, 8, 32'h84);
        put(16, 8, 32'hA0);
        slice_start[15] = 1'b1;
        step("t3.1", pb(20), pb(20));
        clr();
        step("t3.2", '0, '0);

        clr();
        i_hdr(120);
        slice_start[0] = 1'b1;
        step("t4.0", '0, '0);
        clr();
        put(0, 8, 32'h84);
        put(8, 8, 32'hA0);
        step("t4.1", pb(12), pb(12));

        clr();
        i_hdr(8);
        slice_start[14] = 1'b1;
        step("t5.0", pb(28), pb(28));
        clr();
        mb_end = pb(40);
        step("t5.1", pb(40), '0);
        clr();
        mb_end = pb(32);
        slice_end[10] = 1'b1;
        step("t5.2", pb(32), '0);
        clr();
        mb_end = pb(48);
        step("t5.3", '0, '0);

        clr();
        i_hdr(8);
        slice_start[14] = 1'b1;
        step("t6.0", pb(28), pb(28));
        clr();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        mb_end = pb(40);
        step("t6.1", '0, '0);
        clr();
        mb_end = pb(40);
        step("t6.2", '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
